// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
// Holds the priority-holder enum, default widths, the requester port
// indices and a helper that checks whether a word address fits the
// memory index width.
package dmem_arb_pkg;

  typedef enum logic {
    PRI_CPU = 1'b0,
    PRI_DBG = 1'b1
  } pri_e;

  localparam int unsigned DEF_AW = 8;
  localparam int unsigned DEF_DW = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CNT_W  = 4;

  localparam int unsigned PORT_CPU = 0;
  localparam int unsigned PORT_DBG = 1;

  // True when every address bit above the memory index width is zero.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int unsigned       aw);
    return (aw >= ADDR_W) || ((addr >> aw) == '0);
  endfunction

endpackage

// File: rtl/dmem_burst_ctr.sv
// Burst-limited priority tracker for the data-memory arbiter.
// Counts consecutive contested grants to the current priority holder and
// hands priority to the other port after MAX_BURST of them. Any cycle
// without contention returns priority to the CPU and clears the count.
//   clk, rst_n  : clock, asynchronous active-low reset
//   contested   : both ports requesting this cycle
//   holder_gnt  : the current priority holder was granted this cycle
//   pri         : current priority holder
module dmem_burst_ctr
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic contested,
  input  logic holder_gnt,
  output pri_e pri
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_BURST - 1);

  pri_e             pri_q, pri_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    pri_d = pri_q;
    cnt_d = cnt_q;
    if (contested && holder_gnt) begin
      if (cnt_q == LAST) begin
        pri_d = (pri_q == PRI_CPU) ? PRI_DBG : PRI_CPU;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      pri_d = PRI_CPU;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri_q <= PRI_CPU;
      cnt_q <= '0;
    end else begin
      pri_q <= pri_d;
      cnt_q <= cnt_d;
    end
  end

  assign pri = pri_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-ported data memory.
// Port 0 (c_*) is the CPU load/store stage, port 1 (d_*) the debug/loader.
// At most one access is granted per cycle; under contention the priority
// holder wins, with a burst limit so neither side starves.
//   c_req/c_we/c_addr/c_wdata -> c_gnt, c_rvalid, c_rdata   (CPU port)
//   d_req/d_we/d_addr/d_wdata -> d_gnt, d_rvalid, d_rdata   (debug port)
//   cpu_stall                 : CPU is requesting but not granted
//   mem_A/mem_WD/mem_WE/mem_RE: memory pins driven from the granted port
//   mem_RD                    : combinational read data from memory
//   addr_err                  : sticky, set by any out-of-range access
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DW-1:0]     c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DW-1:0]     c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DW-1:0]     d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DW-1:0]     d_rdata,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DW-1:0]     mem_WD,
  output logic              mem_WE,
  output logic              mem_RE,
  input  logic [DW-1:0]     mem_RD,
  output logic              addr_err
);

  pri_e       pri;
  logic [1:0] gnt;
  logic       c_in, d_in;
  logic       contested, holder_gnt;

  logic          c_rvalid_q, c_rvalid_d;
  logic [DW-1:0] c_rdata_q,  c_rdata_d;
  logic          d_rvalid_q, d_rvalid_d;
  logic [DW-1:0] d_rdata_q,  d_rdata_d;
  logic          addr_err_q, addr_err_d;

  dmem_burst_ctr #(
    .MAX_BURST(MAX_BURST)
  ) u_burst (
    .clk       (clk),
    .rst_n     (rst),
    .contested (contested),
    .holder_gnt(holder_gnt),
    .pri       (pri)
  );

  // Grant and memory-pin muxing
  always_comb begin
    c_in      = addr_in_range(c_addr, AW);
    d_in      = addr_in_range(d_addr, AW);
    contested = c_req & d_req;

    gnt           = '0;
    gnt[PORT_CPU] = c_req & (~d_req | (pri == PRI_CPU));
    gnt[PORT_DBG] = d_req & (~c_req | (pri == PRI_DBG));
    holder_gnt    = (pri == PRI_CPU) ? gnt[PORT_CPU] : gnt[PORT_DBG];

    mem_A  = '0;
    mem_WD = '0;
    mem_WE = 1'b0;
    mem_RE = 1'b0;
    if (gnt[PORT_CPU]) begin
      mem_A  = c_addr;
      mem_WD = c_wdata;
      mem_WE = c_we & c_in;
      mem_RE = ~c_we;
    end else if (gnt[PORT_DBG]) begin
      mem_A  = d_addr;
      mem_WD = d_wdata;
      mem_WE = d_we & d_in;
      mem_RE = ~d_we;
    end
  end

  // Read return: capture on the edge closing the grant cycle; an
  // out-of-range read still completes, but with zero data.
  always_comb begin
    c_rvalid_d = gnt[PORT_CPU] & ~c_we;
    c_rdata_d  = c_rdata_q;
    if (c_rvalid_d) c_rdata_d = c_in ? mem_RD : '0;

    d_rvalid_d = gnt[PORT_DBG] & ~d_we;
    d_rdata_d  = d_rdata_q;
    if (d_rvalid_d) d_rdata_d = d_in ? mem_RD : '0;

    addr_err_d = addr_err_q
               | (gnt[PORT_CPU] & ~c_in)
               | (gnt[PORT_DBG] & ~d_in);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      d_rvalid_q <= 1'b0;
      d_rdata_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      c_rvalid_q <= c_rvalid_d;
      c_rdata_q  <= c_rdata_d;
      d_rvalid_q <= d_rvalid_d;
      d_rdata_q  <= d_rdata_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign c_gnt     = gnt[PORT_CPU];
  assign d_gnt     = gnt[PORT_DBG];
  assign cpu_stall = c_req & ~gnt[PORT_CPU];
  assign c_rvalid  = c_rvalid_q;
  assign c_rdata   = c_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign addr_err  = addr_err_q;

endmodule
